sha256_padder: RTL

Front end of the SHA-256 datapath; feeds the compression core.
- Accepts a byte-granular message as a stream of 32-bit big-endian words.
- Applies FIPS 180-4 padding: 0x80 byte, zero fill, then the 64-bit big-endian bit length.
- Emits 512-bit message blocks over a valid/ready handshake, with first/last flags so the core knows when to load the initial H values and when to publish the digest.

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_pad_word.sv | 22 ++
 rtl/sha256_padder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types: word/block geometry, padding byte and
// the padder state encoding.
package sha256_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int MSG_BLOCK_SIZE  = 512;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int LEN_BITS        = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef logic [MSG_BLOCK_SIZE-1:0] msg_block_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } pad_state_t;

  // A word holding only the padding marker in its earliest byte.
  function automatic logic [WORD_SIZE-1:0] pad_lead_word();
    return {PAD_BYTE, 24'h000000};
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Formats the final message word: keeps the first nbytes bytes, places the
// 0x80 marker right after them and zeroes the rest.
module sha256_pad_word (
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] word,
  output logic        ovf
);
  import sha256_pkg::*;

  always_comb begin
    word = '0;
    ovf  = (nbytes == 3'd4);
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes)
        word[31-8*i -: 8] = data[31-8*i -: 8];
      else if (3'(i) == nbytes)
        word[31-8*i -: 8] = PAD_BYTE;
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks
// with FIPS 180-4 padding. Define SHA256_PADDER_ERR_EN to add the sticky err output.
module sha256_padder #(
  parameter int LEN_W     = 64,
  parameter int WORD_SIZE = sha256_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic [2:0]           in_bytes,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [511:0]         out_block,
  output logic                 out_first,
  output logic                 out_last
`ifdef SHA256_PADDER_ERR_EN
  ,
  output logic                 err
`endif
);
  import sha256_pkg::*;

  pad_state_t       state, state_nx;
  msg_block_t       blk, fill_blk, extra_blk;
  logic [3:0]       widx;
  logic [LEN_W-1:0] length, new_len;
  logic             first_pend, extra_pend, owe80, last_r;

  logic             accept, bad;
  logic [2:0]       eff_bytes;
  logic [31:0]      pw;
  logic             pw_ovf;
  logic [4:0]       p;

  assign accept = in_valid & in_ready;

`ifdef SHA256_PADDER_ERR_EN
  assign bad       = (in_bytes > 3'd4) | ((in_bytes != 3'd4) & ~in_last);
  assign eff_bytes = in_bytes;
`else
  assign bad       = 1'b0;
  assign eff_bytes = (~in_last | (in_bytes > 3'd4)) ? 3'd4 : in_bytes;
`endif

  assign new_len = length + (LEN_W'(eff_bytes) << 3);

  sha256_pad_word u_pad_word (
    .data   (in_data),
    .nbytes (eff_bytes),
    .word   (pw),
    .ovf    (pw_ovf)
  );

  // p is the word index that receives the 0x80 marker; 16 means "next block".
  assign p = {1'b0, widx} + {4'd0, pw_ovf};

  always_comb begin
    fill_blk = blk;
    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
      if (5'(k) == {1'b0, widx})
        fill_blk[511-32*k -: 32] = in_last ? pw : in_data;
      else if (in_last && (5'(k) > {1'b0, widx}))
        fill_blk[511-32*k -: 32] = (pw_ovf && (5'(k) == p)) ? pad_lead_word() : '0;
    end
    if (in_last && (p <= 5'd13))
      fill_blk[63:0] = 64'(new_len);
  end

  always_comb begin
    extra_blk         = '0;
    extra_blk[63:0]   = 64'(length);
    if (owe80)
      extra_blk[511:480] = pad_lead_word();
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = rst_n & (state == FILL);
    out_valid = (state == EMIT);
    out_first = (state == EMIT) & first_pend;
    out_last  = (state == EMIT) & last_r;
    case (state)
      FILL:    if (accept && !bad && (in_last || (widx == 4'd15))) state_nx = EMIT;
      EMIT:    if (out_ready) state_nx = extra_pend ? EXTRA : FILL;
      EXTRA:   state_nx = EMIT;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk        <= '0;
      widx       <= '0;
      length     <= '0;
      first_pend <= 1'b1;
      extra_pend <= 1'b0;
      owe80      <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept && !bad) begin
            blk    <= fill_blk;
            length <= new_len;
            widx   <= widx + 4'd1;
            if (in_last) begin
              last_r     <= (p <= 5'd13);
              extra_pend <= (p > 5'd13);
              owe80      <= (p == 5'd16);
            end else if (widx == 4'd15) begin
              last_r     <= 1'b0;
              extra_pend <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            first_pend <= 1'b0;
            widx       <= '0;
            if (!extra_pend && last_r) begin
              length     <= '0;
              first_pend <= 1'b1;
            end
          end
        end
        EXTRA: begin
          blk        <= extra_blk;
          last_r     <= 1'b1;
          extra_pend <= 1'b0;
          owe80      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_block = blk;

`ifdef SHA256_PADDER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               err <= 1'b0;
    else if (accept && bad)   err <= 1'b1;
  end
`endif

endmodule
